// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Imported by dmem_arbiter and its bench.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF   = 14;
   localparam int DATA_W_DEF   = 32;
   localparam int MAX_WAIT_DEF = 4;

   typedef enum logic [1:0] {
      LOAD,
      RUN,
      DRAIN
   } mode_e;

   typedef enum logic {
      IDLE,
      ACCESS
   } acc_e;

   typedef enum logic {
      CPU,
      UPG
   } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data RAM between the CPU and the UART programmer.
// A LOAD/RUN/DRAIN mode FSM decides who may use the RAM and gates the CPU.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              upg_req,
   input  logic [ADDR_W-1:0] upg_adr,
   input  logic [DATA_W-1:0] upg_wdata,
   output logic              upg_ack,
   input  logic              upg_done,
   input  logic              upg_start,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_adr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              cpu_run
);

   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_TOP = CW'(MAX_WAIT);

   mode_e             mode_q, mode_d;
   acc_e              acc_q, acc_d;
   owner_e            own_q, own_d;
   logic              we_q;
   logic              armed_q;
   logic [CW-1:0]     wait_q, wait_d;
   logic [DATA_W-1:0] rdata_q;

   logic cpu_win;
   logic upg_win;
   logic grant;
   logic starved;

   assign starved = upg_req && (wait_q == WAIT_TOP);

   // armed_q holds off grants until the first edge after reset release
   always_comb begin
      cpu_win = 1'b0;
      upg_win = 1'b0;
      if (armed_q && acc_q == IDLE) begin
         unique case (mode_q)
            LOAD: upg_win = upg_req;
            RUN: begin
               if (!upg_start) begin
                  if (starved)      upg_win = 1'b1;
                  else if (cpu_req) cpu_win = 1'b1;
                  else if (upg_req) upg_win = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign grant = cpu_win | upg_win;

   always_comb begin
      ram_en    = grant;
      ram_we    = upg_win | (cpu_win & cpu_we);
      ram_adr   = '0;
      ram_wdata = '0;
      if (upg_win) begin
         ram_adr   = upg_adr;
         ram_wdata = upg_wdata;
      end else if (cpu_win) begin
         ram_adr   = cpu_adr;
         ram_wdata = cpu_wdata;
      end
   end

   assign cpu_ack   = (acc_q == ACCESS) && (own_q == CPU);
   assign upg_ack   = (acc_q == ACCESS) && (own_q == UPG);
   assign cpu_rdata = (cpu_ack && !we_q) ? ram_rdata : rdata_q;
   assign cpu_run   = (mode_q == RUN);

   always_comb begin
      mode_d = mode_q;
      unique case (mode_q)
         LOAD: begin
            if (armed_q && upg_done && acc_q == IDLE && !upg_req)
               mode_d = RUN;
         end
         RUN: begin
            if (upg_start)
               mode_d = DRAIN;
         end
         DRAIN: begin
            if (acc_q == IDLE)
               mode_d = LOAD;
         end
         default: mode_d = LOAD;
      endcase
   end

   always_comb begin
      acc_d  = grant ? ACCESS : IDLE;
      own_d  = own_q;
      wait_d = wait_q;
      if (grant)
         own_d = upg_win ? UPG : CPU;
      if (mode_q != RUN || mode_d != RUN || upg_win)
         wait_d = '0;
      else if (cpu_win && upg_req && wait_q != WAIT_TOP)
         wait_d = wait_q + CW'(1);
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         mode_q  <= LOAD;
         acc_q   <= IDLE;
         own_q   <= CPU;
         we_q    <= 1'b0;
         armed_q <= 1'b0;
         wait_q  <= '0;
         rdata_q <= '0;
      end else begin
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         own_q   <= own_d;
         armed_q <= 1'b1;
         wait_q  <= wait_d;
         if (grant)
            we_q <= ram_we;
         if (cpu_ack && !we_q)
            rdata_q <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous RAM model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int AW = 14;
   localparam int DW = 32;

   logic          clock;
   logic          rst;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_adr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          upg_req;
   logic [AW-1:0] upg_adr;
   logic [DW-1:0] upg_wdata;
   logic          upg_ack;
   logic          upg_done;
   logic          upg_start;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_adr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          cpu_run;

   int vecs = 0;
   int errs = 0;

   logic [DW-1:0] mem [0:63];

   dmem_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .MAX_WAIT(4)
   ) dut (
      .clock    (clock),
      .rst      (rst),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_adr  (cpu_adr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .cpu_ack  (cpu_ack),
      .upg_req  (upg_req),
      .upg_adr  (upg_adr),
      .upg_wdata(upg_wdata),
      .upg_ack  (upg_ack),
      .upg_done (upg_done),
      .upg_start(upg_start),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_adr  (ram_adr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .cpu_run  (cpu_run)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      ram_rdata = '0;
   end

   always @(posedge clock) begin
      if (ram_en) begin
         ram_rdata <= mem[ram_adr[5:0]];
         if (ram_we) mem[ram_adr[5:0]] <= ram_wdata;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clock);
      #1;
   endtask

   task automatic smp;
      @(negedge clock);
   endtask

   initial begin
      logic exp_upg;
      rst       = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_adr   = 14'd3;
      cpu_wdata = '0;
      upg_req   = 1'b1;
      upg_adr   = 14'd3;
      upg_wdata = 32'h1234_5678;
      upg_done  = 1'b0;
      upg_start = 1'b0;

      // reset: everything quiet even with both requests up
      nxt; smp;
      chk("rst_acks",  {cpu_ack, upg_ack}, 2'b00);
      chk("rst_ram",   {ram_en, ram_we}, 2'b00);
      chk("rst_adr",   ram_adr, 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_run",   cpu_run, 0);

      nxt; rst = 1'b1;
      smp; chk("release_no_grant", ram_en, 0);

      // LOAD: programmer write to adr 3, CPU read ignored
      nxt; smp;
      chk("load_grant", {ram_en, ram_we}, 2'b11);
      chk("load_adr",   ram_adr, 3);
      chk("load_wdata", ram_wdata, 32'h1234_5678);
      chk("load_cpuack0", cpu_ack, 0);
      nxt; smp;
      chk("load_ack", {cpu_ack, upg_ack}, 2'b01);
      chk("load_access_en", ram_en, 0);
      nxt; upg_req = 1'b0;
      smp;
      chk("load_cpu_ignored", {ram_en, cpu_ack}, 2'b00);

      // LOAD -> RUN, then CPU reads the programmed word
      nxt; upg_done = 1'b1;
      smp;
      chk("load_still", {cpu_run, ram_en}, 2'b00);
      nxt; smp;
      chk("run_entered", cpu_run, 1);
      chk("run_cpu_grant", {ram_en, ram_we}, 2'b10);
      chk("run_cpu_adr", ram_adr, 3);
      nxt; smp;
      chk("run_cpu_ack", {cpu_ack, upg_ack}, 2'b10);
      chk("run_cpu_rdata", cpu_rdata, 32'h1234_5678);
      nxt; cpu_req = 1'b0;
      smp;
      chk("rdata_hold", cpu_rdata, 32'h1234_5678);
      chk("idle_ack0", {cpu_ack, ram_en}, 2'b00);

      // both held: four CPU grants, then the programmer
      nxt;
      cpu_req   = 1'b1;
      upg_req   = 1'b1;
      upg_adr   = 14'd10;
      upg_wdata = 32'hCAFE_0010;
      for (int k = 0; k < 10; k++) begin
         exp_upg = (k % 5 == 4);
         smp;
         chk($sformatf("arb_grant%0d", k), {ram_en, ram_we}, {1'b1, exp_upg});
         nxt; smp;
         chk($sformatf("arb_ack%0d", k), {cpu_ack, upg_ack}, {!exp_upg, exp_upg});
         if (!exp_upg)
            chk($sformatf("arb_rdata%0d", k), cpu_rdata, 32'h1234_5678);
         nxt;
      end
      cpu_req = 1'b0;
      upg_req = 1'b0;
      smp; chk("withdrawn_no_grant", ram_en, 0);

      // upg_start while a CPU read is in its access cycle
      nxt;
      cpu_req = 1'b1;
      cpu_adr = 14'd10;
      smp; chk("drain_pre_grant", {ram_en, ram_we}, 2'b10);
      nxt;
      upg_start = 1'b1;
      upg_done  = 1'b0;
      smp;
      chk("drain_ack", {cpu_ack, upg_ack}, 2'b10);
      chk("drain_rdata", cpu_rdata, 32'hCAFE_0010);
      chk("drain_run_before", cpu_run, 1);
      nxt; upg_start = 1'b0;
      smp; chk("drain_cycle", {cpu_run, ram_en, cpu_ack}, 3'b000);
      nxt; smp; chk("drain_load", {cpu_run, ram_en, cpu_ack}, 3'b000);
      nxt; smp; chk("drain_pending", {cpu_run, ram_en, cpu_ack}, 3'b000);

      // done raised together with a pending programmer write
      nxt;
      cpu_req   = 1'b0;
      upg_req   = 1'b1;
      upg_adr   = 14'd20;
      upg_wdata = 32'h0BAD_F00D;
      upg_done  = 1'b1;
      smp;
      chk("done_wr_grant", {ram_en, ram_we, cpu_run}, 3'b110);
      chk("done_wr_adr", ram_adr, 20);
      nxt; smp;
      chk("done_wr_ack", {upg_ack, cpu_run}, 2'b10);
      nxt; upg_req = 1'b0;
      smp; chk("done_not_yet_run", cpu_run, 0);
      nxt;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_adr   = 14'd7;
      cpu_wdata = 32'hDEAD_BEEF;
      smp;
      chk("done_run", cpu_run, 1);
      chk("wr_grant", {ram_en, ram_we}, 2'b11);
      chk("wr_wdata", ram_wdata, 32'hDEAD_BEEF);

      // reset lands in the access cycle of the CPU write
      nxt;
      rst      = 1'b0;
      upg_done = 1'b0;
      #1;
      chk("abort_acks", {cpu_ack, upg_ack}, 2'b00);
      chk("abort_ram", {ram_en, ram_we}, 2'b00);
      chk("abort_bus", {ram_adr, ram_wdata}, 0);
      chk("abort_rdata", cpu_rdata, 0);
      chk("abort_run", cpu_run, 0);
      nxt; nxt; rst = 1'b1;
      smp; chk("post_rst_quiet", {cpu_run, ram_en, cpu_ack}, 3'b000);
      nxt; smp; chk("post_rst_load", {cpu_run, ram_en, cpu_ack}, 3'b000);
      nxt; smp; chk("post_rst_load2", {cpu_run, ram_en, cpu_ack}, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Parameter MAX_WAIT, default 4, consecutive CPU grants allowed while UART request waits.
REQ-004 clock  in  1  single block clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-007 cpu_we  in  1  1=write, 0=read.
REQ-008 cpu_adr  in  ADDR_W  CPU word address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1.
REQ-011 cpu_ack  out  1  one-cycle completion pulse.
REQ-012 upg_req  in  1  UART programmer write request, held until upg_ack.
REQ-013 upg_adr  in  ADDR_W  programmer word address.
REQ-014 upg_wdata  in  DATA_W  programmer write data.
REQ-015 upg_ack  out  1  one-cycle completion pulse.
REQ-016 upg_done  in  1  level: programming finished.
REQ-017 upg_start  in  1  pulse: re-enter programming mode.
REQ-018 ram_en, ram_we  out  1 each  RAM port enable/write-enable.
REQ-019 ram_adr  out  ADDR_W; ram_wdata  out  DATA_W; ram_rdata  in  DATA_W (1-cycle synchronous read latency).
REQ-020 cpu_run  out  1  high only in RUN mode; gates CPU PC advance.

Function
REQ-021 Mode FSM SHALL have states LOAD, RUN, DRAIN; access FSM SHALL have states IDLE, ACCESS.
REQ-022 LOAD: only upg_req granted; cpu_req ignored, cpu_ack stays 0.
REQ-023 LOAD->RUN when upg_done=1, access FSM IDLE and upg_req=0; else remain LOAD.
REQ-024 RUN: upg_start=1 -> DRAIN; upg_start ignored in LOAD/DRAIN.
REQ-025 DRAIN: no new grants; in-flight access completes with its ack; then -> LOAD next cycle.
REQ-026 IDLE with eligible request: grant, drive ram_en=1, ram_we, ram_adr, ram_wdata from winner; go ACCESS.
REQ-027 ACCESS (exactly one cycle): assert winner's ack; for CPU read cpu_rdata=ram_rdata; return IDLE; max throughput one access per 2 cycles.
REQ-028 ram_en=0 and ram_we=0 in every non-grant cycle; ram_we=1 for all UART grants.
REQ-029 RUN arbitration: CPU priority, except upg wins when wait_cnt==MAX_WAIT.
REQ-030 wait_cnt increments on each CPU grant with upg_req=1, saturates at MAX_WAIT, clears on UART grant or leaving RUN.
REQ-031 Both requests with wait_cnt<MAX_WAIT: CPU granted, UART waits.
REQ-032 Request deasserted before grant: no access, no ack, no error.
REQ-033 Acks SHALL never be asserted simultaneously; ack without prior grant is illegal.
REQ-034 cpu_rdata holds last read value when cpu_ack=0.

Reset
REQ-035 On rst=0 (asynchronous): mode=LOAD, access=IDLE, wait_cnt=0, cpu_ack=0, upg_ack=0, ram_en=0, ram_we=0, ram_adr=0, ram_wdata=0, cpu_rdata=0, cpu_run=0.
REQ-036 Reset mid-ACCESS SHALL abort the access with no ack; release synchronous to clock edge.

Structure
REQ-037 Package dmem_arb_pkg SHALL hold mode enum (LOAD/RUN/DRAIN), access enum (IDLE/ACCESS), owner enum (CPU/UPG) and default parameter constants.
REQ-038 Single flat module; no sub-module required (starvation counter inline).

Verification
REQ-039 Reset, upg_req writes 0x1234_5678 to adr 3, cpu_req read adr 3 held -> upg_ack 2nd cycle, cpu_ack=0 throughout LOAD.
REQ-040 upg_done=1, then CPU read adr 3 -> cpu_run=1, cpu_ack 2 cycles after request, cpu_rdata=0x1234_5678.
REQ-041 RUN, cpu_req and upg_req held continuously, MAX_WAIT=4 -> grant order CPU,CPU,CPU,CPU,UPG repeating; wait_cnt never >4.
REQ-042 upg_start during CPU ACCESS -> cpu_ack still issued, DRAIN one cycle, LOAD, cpu_run=0, pending cpu_req unserved.
REQ-043 rst=0 in ACCESS cycle of CPU write -> no cpu_ack, all outputs zero immediately, mode LOAD after release.
REQ-044 LOAD, upg_done=1 while upg_req=1 -> write completes with upg_ack before RUN entered.
